// File: rtl/branch_resolve_queue_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_pkg / branch_resolve_queue_if
//
// Purpose : shared direction type plus the bundle of fetch-side, execute-side
//           and table/PC-mux-side signals used by branch_resolve_queue.
//
// Signal summary (direction as seen by the queue, modport slave):
//   push, push_pc[31:0], push_dir, push_target[31:0]      in   fetch prediction
//   full, empty                                           out  occupancy
//   resolve, resolve_taken, resolve_target[31:0], flush   in   execute / squash
//   predict_en, resolved_pc[31:0], predictionFailed       out  table update
//   redirect, redirect_pc[31:0]                           out  PC-mux redirect
//   underflow_err                                         out  sticky error
//   branch_cnt[31:0], mispredict_cnt[31:0]                out  perf counters
//
// The master modport is the view of the surrounding pipeline (or a bench).
// -----------------------------------------------------------------------------
package branch_resolve_queue_pkg;
    typedef enum logic {
        NOTTAKEN = 1'b0,
        TAKEN    = 1'b1
    } predictmux_t;
endpackage

interface branch_resolve_queue_if;
    // Fetch side
    logic                                push;
    logic [31:0]                         push_pc;
    branch_resolve_queue_pkg::predictmux_t push_dir;
    logic [31:0]                         push_target;
    logic                                full;
    logic                                empty;
    // Execute side
    logic                                resolve;
    logic                                resolve_taken;
    logic [31:0]                         resolve_target;
    logic                                flush;
    // Direction table / PC mux side
    logic                                predict_en;
    logic [31:0]                         resolved_pc;
    logic                                predictionFailed;
    logic                                redirect;
    logic [31:0]                         redirect_pc;
    // Status
    logic                                underflow_err;
    logic [31:0]                         branch_cnt;
    logic [31:0]                         mispredict_cnt;

    modport master (
        output push, push_pc, push_dir, push_target,
        output resolve, resolve_taken, resolve_target, flush,
        input  full, empty,
        input  predict_en, resolved_pc, predictionFailed, redirect, redirect_pc,
        input  underflow_err, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  push, push_pc, push_dir, push_target,
        input  resolve, resolve_taken, resolve_target, flush,
        output full, empty,
        output predict_en, resolved_pc, predictionFailed, redirect, redirect_pc,
        output underflow_err, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Purpose : holds every direction prediction issued by fetch (program order)
//           until execute resolves it (oldest first). Each resolve produces a
//           one-cycle update strobe for the local direction table and, on a
//           direction or target miss, a redirect to the PC mux. A redirect or
//           an external flush discards every in-flight (wrong-path) entry.
//
// Parameters : DEPTH - in-flight predictions, power of two, >= 2
//
// Ports :
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - branch_resolve_queue_if.slave (push / resolve / flush inputs,
//          full / empty, update strobe, redirect, error and counter outputs)
//
// Build option : define BRQ_PERF_CNT_EN to instantiate the 32-bit wrapping
//   branch_cnt / mispredict_cnt counters; otherwise both read as 0 and no
//   counter flops exist.
// -----------------------------------------------------------------------------
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Correct next PC once the real direction is known.
    function automatic logic [31:0] next_pc(input logic        taken,
                                            input logic [31:0] target,
                                            input logic [31:0] pc);
        return taken ? target : pc + 32'd4;
    endfunction

    // -------------------------------------------------------------------------
    // Storage and occupancy (stage p0: queue state)
    // -------------------------------------------------------------------------
    logic [31:0]  pc_mem  [DEPTH];
    predictmux_t  dir_mem [DEPTH];
    logic [31:0]  tgt_mem [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic        full_p0;
    logic        empty_p0;
    logic        pop_p0;
    logic        push_ok_p0;
    logic        dir_miss_p0;
    logic        tgt_miss_p0;
    logic        redirect_p0;
    logic        squash_p0;
    logic [31:0] head_pc_p0;
    logic        head_taken_p0;
    logic [31:0] head_tgt_p0;

    assign full_p0  = (count_q == CNT_W'(DEPTH));
    assign empty_p0 = (count_q == '0);

    assign head_pc_p0    = pc_mem[head_q];
    assign head_taken_p0 = (dir_mem[head_q] == TAKEN);
    assign head_tgt_p0   = tgt_mem[head_q];

    assign pop_p0      = bus.resolve && !empty_p0;
    assign dir_miss_p0 = head_taken_p0 != bus.resolve_taken;
    assign tgt_miss_p0 = head_taken_p0 && bus.resolve_taken &&
                         (head_tgt_p0 != bus.resolve_target);

    // Flush owns the front end, so it masks the redirect of a same-cycle miss.
    assign redirect_p0 = pop_p0 && (dir_miss_p0 || tgt_miss_p0) && !bus.flush;
    // Either event empties the queue; younger entries are wrong-path.
    assign squash_p0   = bus.flush || redirect_p0;
    // A pop in the same cycle frees a slot even when currently full.
    assign push_ok_p0  = bus.push && (!full_p0 || pop_p0) && !squash_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (squash_p0) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop_p0)
                head_q <= head_q + PTR_W'(1);
            if (push_ok_p0)
                tail_q <= tail_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok_p0) - CNT_W'(pop_p0);
        end
    end

    // Entry payload carries no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push_ok_p0) begin
            pc_mem[tail_q]  <= bus.push_pc;
            dir_mem[tail_q] <= bus.push_dir;
            tgt_mem[tail_q] <= bus.push_target;
        end
    end

    // -------------------------------------------------------------------------
    // Registered update / redirect outputs (stage p1)
    // -------------------------------------------------------------------------
    logic        vld_p1;
    logic [31:0] resolved_pc_p1;
    logic        pred_fail_p1;
    logic        redirect_p1;
    logic [31:0] redirect_pc_p1;
    logic        underflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1         <= 1'b0;
            resolved_pc_p1 <= '0;
            pred_fail_p1   <= 1'b0;
            redirect_p1    <= 1'b0;
            redirect_pc_p1 <= '0;
            underflow_q    <= 1'b0;
        end else begin
            vld_p1       <= pop_p0;
            pred_fail_p1 <= pop_p0 && dir_miss_p0;
            redirect_p1  <= redirect_p0;
            if (pop_p0) begin
                resolved_pc_p1 <= head_pc_p0;
                redirect_pc_p1 <= next_pc(bus.resolve_taken, bus.resolve_target,
                                          head_pc_p0);
            end
            if (bus.resolve && empty_p0)
                underflow_q <= 1'b1;
        end
    end

`ifdef BRQ_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (pop_p0)
                branch_cnt_q <= branch_cnt_q + 32'd1;
            if (redirect_p0)
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
`else
    assign bus.branch_cnt     = '0;
    assign bus.mispredict_cnt = '0;
`endif

    assign bus.full             = full_p0;
    assign bus.empty            = empty_p0;
    assign bus.predict_en       = vld_p1;
    assign bus.resolved_pc      = resolved_pc_p1;
    assign bus.predictionFailed = pred_fail_p1;
    assign bus.redirect         = redirect_p1;
    assign bus.redirect_pc      = redirect_pc_p1;
    assign bus.underflow_err    = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a queue-based reference model of the branch resolve queue.
// -----------------------------------------------------------------------------
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_queue_if bus ();

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        dir;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic        e_pe, e_pf, e_red, e_uf;
    logic [31:0] e_rpc, e_rdpc, e_bc, e_mc;

    task automatic model_reset();
        q.delete();
        e_pe = 0; e_pf = 0; e_red = 0; e_uf = 0;
        e_rpc = 0; e_rdpc = 0; e_bc = 0; e_mc = 0;
    endtask

    task automatic model_step(input logic p, input logic [31:0] ppc,
                              input logic pd, input logic [31:0] pt,
                              input logic r, input logic rt,
                              input logic [31:0] rtg, input logic f);
        ent_t e;
        logic dmiss, tmiss;
        e_pe = 0; e_pf = 0; e_red = 0;
        if (r && q.size() == 0) e_uf = 1;
        if (r && q.size() > 0) begin
            e = q.pop_front();
            dmiss  = (e.dir != rt);
            tmiss  = e.dir && rt && (e.tgt != rtg);
            e_pe   = 1;
            e_rpc  = e.pc;
            e_pf   = dmiss;
            e_red  = (dmiss || tmiss) && !f;
            e_rdpc = rt ? rtg : e.pc + 32'd4;
            e_bc   = e_bc + 1;
            if (e_red) e_mc = e_mc + 1;
        end
        if (f || e_red) q.delete();
        else if (p && q.size() < DEPTH) begin
            e.pc = ppc; e.dir = pd; e.tgt = pt;
            q.push_back(e);
        end
    endtask

    task automatic check_all();
        check_eq("predict_en",       32'(bus.predict_en),       32'(e_pe));
        check_eq("predictionFailed", 32'(bus.predictionFailed), 32'(e_pf));
        check_eq("redirect",         32'(bus.redirect),         32'(e_red));
        check_eq("resolved_pc",      bus.resolved_pc,           e_rpc);
        check_eq("redirect_pc",      bus.redirect_pc,           e_rdpc);
        check_eq("underflow_err",    32'(bus.underflow_err),    32'(e_uf));
        check_eq("full",  32'(bus.full),  32'(q.size() == DEPTH));
        check_eq("empty", 32'(bus.empty), 32'(q.size() == 0));
`ifdef BRQ_PERF_CNT_EN
        check_eq("branch_cnt",     bus.branch_cnt,     e_bc);
        check_eq("mispredict_cnt", bus.mispredict_cnt, e_mc);
`else
        check_eq("branch_cnt",     bus.branch_cnt,     32'd0);
        check_eq("mispredict_cnt", bus.mispredict_cnt, 32'd0);
`endif
    endtask

    // One clock: drive at the falling edge, model, then check at next falling edge.
    task automatic step(input logic p, input logic [31:0] ppc, input logic pd,
                        input logic [31:0] pt, input logic r, input logic rt,
                        input logic [31:0] rtg, input logic f);
        bus.push           = p;
        bus.push_pc        = ppc;
        bus.push_dir       = pd ? TAKEN : NOTTAKEN;
        bus.push_target    = pt;
        bus.resolve        = r;
        bus.resolve_taken  = rt;
        bus.resolve_target = rtg;
        bus.flush          = f;
        model_step(p, ppc, pd, pt, r, rt, rtg, f);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_push(input logic [31:0] pc, input logic d, input logic [31:0] t);
        step(1, pc, d, t, 0, 0, 0, 0);
    endtask

    task automatic do_resolve(input logic rt, input logic [31:0] rtg);
        step(0, 0, 0, 0, 1, rt, rtg, 0);
    endtask

    logic [31:0] bc0, mc0;
    logic        rp, rr, rf, rpd, rrt;
    logic [31:0] rpc, rpt, rrtg;

    initial begin
        bus.push = 0; bus.push_pc = 0; bus.push_dir = NOTTAKEN; bus.push_target = 0;
        bus.resolve = 0; bus.resolve_taken = 0; bus.resolve_target = 0; bus.flush = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full",  32'(bus.full),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Correct taken prediction
        do_push(32'h100, 1, 32'h200);
        do_resolve(1, 32'h200);
        check_eq("t1_pe",  32'(bus.predict_en), 32'd1);
        check_eq("t1_rpc", bus.resolved_pc,     32'h100);
        check_eq("t1_red", 32'(bus.redirect),   32'd0);
        check_eq("t1_pe_pulse_prev", 32'(bus.predictionFailed), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t1_pe_pulse", 32'(bus.predict_en), 32'd0);

        // Direction misses both ways
        do_push(32'h104, 0, 32'h0);
        do_resolve(1, 32'h300);
        check_eq("t2_pf",   32'(bus.predictionFailed), 32'd1);
        check_eq("t2_rdpc", bus.redirect_pc,           32'h300);
        do_push(32'h108, 1, 32'h400);
        do_resolve(0, 32'h0);
        check_eq("t2b_red",  32'(bus.redirect), 32'd1);
        check_eq("t2b_rdpc", bus.redirect_pc,   32'h10C);

        // Target miss only
        do_push(32'h110, 1, 32'h200);
        do_resolve(1, 32'h204);
        check_eq("t3_pf",   32'(bus.predictionFailed), 32'd0);
        check_eq("t3_red",  32'(bus.redirect),         32'd1);
        check_eq("t3_rdpc", bus.redirect_pc,           32'h204);

        // Fill, overflow drop, push+resolve across pointer wrap
        for (int i = 0; i < 4; i++) do_push(32'h200 + 32'(i * 4), 1, 32'h800);
        check_eq("t4_full", 32'(bus.full), 32'd1);
        do_push(32'h210, 1, 32'h800);
        step(1, 32'h214, 1, 32'h800, 1, 1, 32'h800, 0);
        check_eq("t4_full_kept", 32'(bus.full), 32'd1);
        for (int i = 0; i < 4; i++) do_resolve(1, 32'h800);
        check_eq("t4_last_rpc", bus.resolved_pc, 32'h214);
        check_eq("t4_empty",    32'(bus.empty),  32'd1);

        // Mispredict head with a same-cycle push, then underflow
        for (int i = 0; i < 3; i++) do_push(32'h300 + 32'(i * 4), 1, 32'h900);
        step(1, 32'h30C, 1, 32'h900, 1, 0, 32'h0, 0);
        check_eq("t5_empty", 32'(bus.empty), 32'd1);
        do_resolve(1, 32'h900);
        check_eq("t5_uf", 32'(bus.underflow_err), 32'd1);
        check_eq("t5_pe", 32'(bus.predict_en),    32'd0);

        // Ten resolves with three mispredicts
        bc0 = bus.branch_cnt; mc0 = bus.mispredict_cnt;
        for (int i = 0; i < 10; i++) begin
            do_push(32'h400 + 32'(i * 4), 1, 32'h500);
            do_resolve((i % 3 == 0 && i < 9) ? 1'b0 : 1'b1, 32'h500);
        end
`ifdef BRQ_PERF_CNT_EN
        check_eq("t6_bc", bus.branch_cnt - bc0,     32'd10);
        check_eq("t6_mc", bus.mispredict_cnt - mc0, 32'd3);
`else
        check_eq("t6_bc", bus.branch_cnt - bc0,     32'd0);
        check_eq("t6_mc", bus.mispredict_cnt - mc0, 32'd0);
`endif
        // Flush alongside a mispredicting resolve
        mc0 = bus.mispredict_cnt;
        do_push(32'h600, 1, 32'h700);
        step(1, 32'h604, 1, 32'h0, 1, 0, 32'h0, 1);
        check_eq("t7_pe",  32'(bus.predict_en),       32'd1);
        check_eq("t7_pf",  32'(bus.predictionFailed), 32'd1);
        check_eq("t7_red", 32'(bus.redirect),         32'd0);
        check_eq("t7_mc",  bus.mispredict_cnt,        mc0);
        check_eq("t7_empty", 32'(bus.empty),          32'd1);

        // Asynchronous reset in the middle of traffic
        do_push(32'hA00, 1, 32'hB00);
        do_push(32'hA04, 0, 32'h0);
        do_resolve(1, 32'hB00);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, 1, 1, 32'h0, 0);
        check_eq("t8_no_strobe", 32'(bus.predict_en), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rp   = ($urandom_range(0, 99) < 60);
            rr   = ($urandom_range(0, 99) < 50);
            rf   = ($urandom_range(0, 99) < 3);
            rpd  = 1'($urandom_range(0, 1));
            rpc  = 32'h1000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            rpt  = 32'h200 + (32'($urandom_range(0, 2)) << 8);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                rrt  = q[0].dir;
                rrtg = q[0].dir ? q[0].tgt : 32'h0;
                if ($urandom_range(0, 7) == 0) rrtg = rpt;
            end else begin
                rrt  = 1'($urandom_range(0, 1));
                rrtg = 32'h200 + (32'($urandom_range(0, 2)) << 8);
            end
            step(rp, rpc, rpd, rpt, rr, rrt, rrtg, rf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
